// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the 8N1 serial receive path: state encoding and frame constants.
package uart_rx_byte_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned DATA_BITS            = 8;
    localparam logic        STOP_LEVEL           = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter with synchronous clear; flags the mid-bit and full-bit terminal counts.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_mid_done,
    output logic o_full_done
);

    localparam logic [CNT_W-1:0] MID_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_mid_done  = (r_cnt == MID_LAST);
    assign o_full_done = (r_cnt == FULL_LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 receiver with one-entry byte buffer, level read interrupt, framing and overrun reporting.
//
// state | meaning
// IDLE  | line idle; arms on a high, starts on a following low
// START | waiting for mid start bit; a high there is a glitch
// DATA  | sampling 8 data bits LSB-first at mid-bit
// STOP  | sampling stop bit at its middle, then deliver/drop/frame error
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    input  logic       cpu_end_read,
    output logic       read_int,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       overrun
);

    logic                 r_sync1;
    logic                 r_sync2;
    rx_state_t            r_state;
    logic                 r_armed;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_read_int;
    logic [7:0]           r_rx_byte;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_rx_s;
    logic w_clear;
    logic w_mid_done;
    logic w_full_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Timer runs from zero at every state entry; IDLE holds it cleared.
    always_comb begin
        w_clear = 1'b1;
        case (r_state)
            IDLE:    w_clear = 1'b1;
            START:   w_clear = w_mid_done;
            DATA:    w_clear = w_full_done;
            STOP:    w_clear = w_full_done;
            default: w_clear = 1'b1;
        endcase
    end

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .o_mid_done  (w_mid_done),
        .o_full_done (w_full_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_armed     <= 1'b0;
            r_bit_idx   <= 3'd0;
            r_shift     <= '0;
            r_read_int  <= 1'b0;
            r_rx_byte   <= 8'h00;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            if (cpu_end_read && r_read_int) begin
                r_read_int <= 1'b0;
                r_overrun  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= START;
                        r_armed <= 1'b0;
                    end
                end
                START: begin
                    if (w_mid_done) begin
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= IDLE;
                            r_armed <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_full_done) begin
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            r_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (w_full_done) begin
                        r_state <= IDLE;
                        // A low stop bit may be a break; require a high before re-arming.
                        r_armed <= w_rx_s;
                        if (w_rx_s == STOP_LEVEL) begin
                            if (!r_read_int || cpu_end_read) begin
                                r_rx_byte  <= r_shift;
                                r_read_int <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign read_int  = r_read_int;
    assign rx_byte   = r_rx_byte;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: directed cases plus random frames against a frame-level model.
module tb_uart_rx_byte;

    localparam int CPB     = 16;
    localparam int LAT     = 2 + CPB / 2 + 9 * CPB + 1;
    localparam int FRAME   = 10 * CPB;
    localparam int EV_DLV  = 0;
    localparam int EV_DROP = 1;
    localparam int EV_FERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_in;
    logic       cpu_end_read;
    logic       read_int;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       overrun;

    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    ev_t  exp_q[$];

    // Frame-level model of the CPU-visible buffer.
    logic       m_pend;
    logic [7:0] m_byte;
    logic       m_ovr;

    logic       p_ri;
    logic       p_ov;
    logic [7:0] p_rx;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_in      (uart_in),
        .cpu_end_read (cpu_end_read),
        .read_int     (read_int),
        .rx_byte      (rx_byte),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d, input int c);
        ev_t e;
        e.kind = kind;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event kind=%0d data=%0h cycle=%0d expected=none", kind, d, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == EV_DLV) chk("delivered_byte", {24'd0, d}, {24'd0, e.data});
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_read_int"}, {31'd0, read_int}, {31'd0, m_pend});
        chk({tag, "_rx_byte"}, {24'd0, rx_byte}, {24'd0, m_byte});
        chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after a rising edge; drives one 8N1 frame bit by bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit ack_at_stop,
                              input int abort_at, input int hold_low);
        int         k;
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        k  = cyc;
        if (abort_at < 0) begin
            if (stop_bit == 1'b0) begin
                expect_ev(EV_FERR, 8'h00, k + LAT);
            end else if (!m_pend || ack_at_stop) begin
                expect_ev(EV_DLV, b, k + LAT);
                m_pend = 1'b1;
                m_byte = b;
                if (ack_at_stop) m_ovr = 1'b0;
            end else begin
                if (!m_ovr) expect_ev(EV_DROP, 8'h00, k + LAT);
                m_ovr = 1'b1;
            end
        end
        for (int t = 0; t < FRAME; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (t == abort_at) begin
                rst = 1'b0;
                #1;
                chk("async_reset_read_int", {31'd0, read_int}, 32'd0);
                chk("async_reset_rx_byte", {24'd0, rx_byte}, 32'd0);
                chk("async_reset_frame_err", {31'd0, frame_err}, 32'd0);
                chk("async_reset_overrun", {31'd0, overrun}, 32'd0);
                m_pend       = 1'b0;
                m_byte       = 8'h00;
                m_ovr        = 1'b0;
                uart_in      = 1'b1;
                cpu_end_read = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b1;
                return;
            end
            uart_in      = fr[t / CPB];
            cpu_end_read = ack_at_stop && (t == LAT - 1);
        end
        @(posedge clk);
        #1;
        if (hold_low > 0) idle(hold_low);
        uart_in = 1'b1;
    endtask

    task automatic ack(input string tag);
        cpu_end_read = 1'b1;
        @(posedge clk);
        #1;
        cpu_end_read = 1'b0;
        if (m_pend) begin
            m_pend = 1'b0;
            m_ovr  = 1'b0;
        end
        check_state(tag);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         gap;

        rst          = 1'b0;
        uart_in      = 1'b1;
        cpu_end_read = 1'b0;
        m_pend       = 1'b0;
        m_byte       = 8'h00;
        m_ovr        = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    p_ri = 1'b0;
                    p_ov = 1'b0;
                    p_rx = 8'h00;
                end else begin
                    if (frame_err === 1'b1) got_ev(EV_FERR, 8'h00);
                    if (read_int === 1'b1 && (!p_ri || rx_byte !== p_rx)) got_ev(EV_DLV, rx_byte);
                    if (overrun === 1'b1 && !p_ov) got_ev(EV_DROP, 8'h00);
                    p_ri = read_int;
                    p_ov = overrun;
                    p_rx = rx_byte;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check_state("reset");
        rst = 1'b1;
        idle(5);

        // Basic receive and acknowledge
        send_frame(8'hA5, 1'b1, 1'b0, -1, 0);
        check_state("a5_rx");
        ack("a5_ack");

        // Overrun, clear, then delivery coincident with acknowledge
        send_frame(8'h3C, 1'b1, 1'b0, -1, 0);
        send_frame(8'hC3, 1'b1, 1'b0, -1, 0);
        check_state("overrun_set");
        ack("overrun_ack");
        send_frame(8'h3C, 1'b1, 1'b0, -1, 0);
        send_frame(8'hC3, 1'b1, 1'b1, -1, 0);
        check_state("coincident_ack");
        ack("coincident_final_ack");

        // Framing error, then a clean frame
        send_frame(8'h55, 1'b0, 1'b0, -1, 0);
        check_state("ferr");
        idle(2);
        send_frame(8'h0F, 1'b1, 1'b0, -1, 0);
        check_state("after_ferr");
        ack("after_ferr_ack");

        // Break: line held low well past a frame time
        send_frame(8'h00, 1'b0, 1'b0, -1, 3 * FRAME);
        check_state("break");
        idle(3);
        send_frame(8'h96, 1'b1, 1'b0, -1, 0);
        check_state("after_break");
        ack("after_break_ack");

        // Short low glitch while idle
        uart_in = 1'b0;
        idle(4);
        uart_in = 1'b1;
        idle(40);
        check_state("glitch");

        // Random frames with random acknowledge behaviour
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 5) != 0);
            send_frame(rb, rs, 1'b0, -1, 0);
            check_state("random_rx");
            if ($urandom_range(0, 3) != 0) ack("random_ack");
            gap = rs ? $urandom_range(0, 4) : $urandom_range(2, 6);
            idle(gap);
        end

        // Asynchronous reset in the middle of a frame
        send_frame(8'hAA, 1'b1, 1'b0, -1, 0);
        send_frame(8'h77, 1'b1, 1'b0, -1, 0);
        check_state("pre_reset");
        send_frame(8'hFF, 1'b1, 1'b0, 4 * CPB, 0);
        idle(3);
        check_state("post_reset_idle");
        send_frame(8'h81, 1'b1, 1'b0, -1, 0);
        check_state("post_reset_rx");
        ack("post_reset_ack");

        idle(20);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
